// File: rtl/taiko_pkg.sv
// Shared types and constants for the taiko note-rendering datapath.
// Build option HIT_ZONE_EN adds the MARK state that repaints the hit-zone marker.
package taiko_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] WHITE = 3'b111;

`ifdef HIT_ZONE_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERASE = 3'd1,
    ST_DRAW  = 3'd2,
    ST_MARK  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERASE = 3'd1,
    ST_DRAW  = 3'd2,
    ST_DONE  = 3'd4
  } state_t;
`endif

  // A 9-bit column sum lands in the framebuffer only below SCREEN_W.
  function automatic logic col_visible(input logic [8:0] col);
    return (col < 9'(SCREEN_W));
  endfunction

endpackage

// File: rtl/sprite_raster_counter.sv
// Row-major px/py raster walker over a SIZE x SIZE square, shared by every plotting state.
// px_nxt/py_nxt expose the value loaded at the next edge so callers can register pixel outputs in step.
module sprite_raster_counter #(
  parameter int SIZE = 8,
  parameter int CW   = $clog2(SIZE)
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          clear,
  output logic [CW-1:0] px,
  output logic [CW-1:0] py,
  output logic [CW-1:0] px_nxt,
  output logic [CW-1:0] py_nxt,
  output logic          last
);

  // Next raster position; SIZE is a power of two so (SIZE-1,SIZE-1) wraps to (0,0).
  always_comb begin
    px_nxt = px;
    py_nxt = py;
    if (clear) begin
      px_nxt = '0;
      py_nxt = '0;
    end else begin
      px_nxt = px + CW'(1);
      if (px == CW'(SIZE - 1)) begin
        py_nxt = py + CW'(1);
      end else begin
        py_nxt = py;
      end
    end
  end

  // Counter state register.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      px <= '0;
      py <= '0;
    end else begin
      px <= px_nxt;
      py <= py_nxt;
    end
  end

  assign last = (px == CW'(SIZE - 1)) && (py == CW'(SIZE - 1));

endmodule

// File: rtl/note_sprite_renderer.sv
// Erases the note sprite at its last position and redraws it at the new one, one pixel per clock.
// Build option HIT_ZONE_EN repaints the white hit-zone outline after every draw.
module note_sprite_renderer #(
  parameter int SIZE   = 8,
  parameter int LANE_Y = 56,
  parameter int HIT_X  = 16
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [7:0] note_x,
  input  logic [2:0] note_color,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);
  import taiko_pkg::*;

  localparam int CW = $clog2(SIZE);

  state_t        state_r, state_nxt_s;
  logic [7:0]    new_x_r, new_x_s, old_x_r;
  logic [2:0]    new_color_r, new_color_s, old_color_r;
  logic          have_old_r;
  logic [CW-1:0] px_s, py_s, px_nxt_s, py_nxt_s;
  logic          last_s, clear_s;
  logic [7:0]    base_x_s;
  logic [2:0]    colour_s;
  logic          active_s, edge_ok_s;
  logic [8:0]    col_sum_s;

  assign clear_s = !((state_r == ST_ERASE) || (state_r == ST_DRAW)
`ifdef HIT_ZONE_EN
                     || (state_r == ST_MARK)
`endif
                    );

  sprite_raster_counter #(.SIZE(SIZE), .CW(CW)) u_counter (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .clear    (clear_s),
    .px       (px_s),
    .py       (py_s),
    .px_nxt   (px_nxt_s),
    .py_nxt   (py_nxt_s),
    .last     (last_s)
  );

  // Next-state logic; a tick is latched only from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    new_x_s     = new_x_r;
    new_color_s = new_color_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_tick) begin
          new_x_s     = note_x;
          new_color_s = note_color;
          if (have_old_r && (note_x == old_x_r) && (note_color == old_color_r)) begin
            state_nxt_s = ST_DONE;
          end else if (have_old_r) begin
            state_nxt_s = ST_ERASE;
          end else begin
            state_nxt_s = ST_DRAW;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ERASE: begin
        if (last_s) state_nxt_s = ST_DRAW;
        else        state_nxt_s = ST_ERASE;
      end
      ST_DRAW: begin
`ifdef HIT_ZONE_EN
        if (last_s) state_nxt_s = ST_MARK;
`else
        if (last_s) state_nxt_s = ST_DONE;
`endif
        else        state_nxt_s = ST_DRAW;
      end
`ifdef HIT_ZONE_EN
      ST_MARK: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_MARK;
      end
`endif
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pixel source for the cycle being entered, so the registered outputs match the counter.
  always_comb begin
    base_x_s  = 8'd0;
    colour_s  = BLACK;
    active_s  = 1'b0;
    edge_ok_s = 1'b1;
    case (state_nxt_s)
      ST_ERASE: begin
        base_x_s = old_x_r;
        colour_s = BLACK;
        active_s = 1'b1;
      end
      ST_DRAW: begin
        base_x_s = new_x_s;
        colour_s = new_color_s;
        active_s = 1'b1;
      end
`ifdef HIT_ZONE_EN
      ST_MARK: begin
        base_x_s  = 8'(HIT_X);
        colour_s  = WHITE;
        active_s  = 1'b1;
        edge_ok_s = (px_nxt_s == '0) || (py_nxt_s == '0) ||
                    (px_nxt_s == CW'(SIZE - 1)) || (py_nxt_s == CW'(SIZE - 1));
      end
`endif
      default: begin
        base_x_s = 8'd0;
        active_s = 1'b0;
      end
    endcase
  end

  assign col_sum_s = {1'b0, base_x_s} + 9'(px_nxt_s);

  // FSM state and sprite position/colour history.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      new_x_r     <= 8'd0;
      new_color_r <= 3'd0;
      old_x_r     <= 8'd0;
      old_color_r <= 3'd0;
      have_old_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      new_x_r     <= new_x_s;
      new_color_r <= new_color_s;
      if ((state_r == ST_DRAW) && last_s) begin
        old_x_r     <= new_x_r;
        old_color_r <= new_color_r;
        have_old_r  <= 1'b1;
      end
    end
  end

  // Registered framebuffer write port and status.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      vga_x      <= active_s ? col_sum_s[7:0] : 8'd0;
      vga_y      <= active_s ? (7'(LANE_Y) + 7'(py_nxt_s)) : 7'd0;
      vga_colour <= active_s ? colour_s : 3'd0;
      vga_plot   <= active_s && edge_ok_s && col_visible(col_sum_s);
      busy       <= active_s;
      done       <= (state_nxt_s == ST_DONE);
    end
  end

endmodule

// File: doc/note_sprite_renderer.md
Name: note_sprite_renderer

Overview:
- Downstream of the note-position control path. Consumes the scrolling note's X position and colour and rasterises an SIZE×SIZE square note sprite into the 160×120 VGA framebuffer.
- Write port is vga_x / vga_y / vga_colour / vga_plot.
- Each frame_tick erases the sprite at its previously drawn position, then draws it at the new position, one pixel per clock.

Parameters:
- SIZE, 8, sprite edge length in pixels (power of two, 2..16).
- LANE_Y, 56, framebuffer row of the sprite's top edge (LANE_Y+SIZE ≤ 120).
- HIT_X, 16, left column of the hit-zone marker (used only with HIT_ZONE_EN).

Ports:
- CLOCK_50 input 1 system clock; all logic on posedge.
- resetn input 1 reset; synchronous, active-low.
- frame_tick input 1 one-cycle pulse requesting a redraw.
- note_x input 8 new sprite left column, 0..159; values >159 are treated as off-screen.
- note_color input 3 new sprite colour, RGB 1 bit each.
- vga_x output 8 framebuffer column.
- vga_y output 7 framebuffer row.
- vga_colour output 3 pixel colour.
- vga_plot output 1 write strobe; one pixel per asserted cycle.
- busy output 1 high while ERASE/DRAW/MARK is active.
- done output 1 one-cycle pulse when a redraw completes.

Behaviour:
- Reset (resetn=0 at posedge):
  - All outputs become 0.
  - State goes to IDLE.
  - have_old, old_x, old_color, px and py are cleared.
  - Reset in mid-operation aborts immediately. No further plot occurs; pixels already written stay in the framebuffer.
- States: IDLE, ERASE, DRAW, MARK (only with the macro), DONE.
- IDLE:
  - frame_tick=1 latches note_x into new_x and note_color into new_color.
  - If have_old=1, new_x==old_x and new_color==old_color: go to DONE with no plotting.
  - Otherwise, if have_old=1: go to ERASE. If have_old=0: go to DRAW.
- Raster counters px, py:
  - Both start at 0; px increments every cycle.
  - When px wraps SIZE-1→0, py increments.
  - After (SIZE-1, SIZE-1) the state advances and both counters clear.
  - Each of ERASE and DRAW lasts exactly SIZE×SIZE cycles.
- ERASE: vga_x=old_x+px, vga_y=LANE_Y+py, vga_colour=000.
- DRAW: vga_x=new_x+px, vga_y=LANE_Y+py, vga_colour=new_color.
- DRAW exit:
  - Go to MARK if HIT_ZONE_EN is defined, else DONE.
  - Update old_x←new_x and old_color←new_color; set have_old=1.
- Clipping:
  - The column sum is computed 9 bits wide.
  - vga_plot=1 only if the sum is ≤159. Clipped cycles still consume time, with vga_plot=0.
  - vga_x carries the low 8 bits regardless.
- Output timing:
  - vga_* are registered. Pixel (px, py) of a state is presented in the same cycle the FSM holds that counter value.
  - The first pixel appears the cycle after the edge that sampled frame_tick.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- busy=1 in ERASE, DRAW and MARK.
- frame_tick is ignored when not in IDLE; there is no queuing and it is not latched.
- note_color=000 still draws; the sprite is black, effectively an erase.
- Full redraw latency, frame_tick to done: 2·SIZE²+1 cycles (129 at SIZE=8). Without erase: SIZE²+1.

Optional Feature:
- HIT_ZONE_EN defined:
  - After DRAW, the MARK state redraws the hit-zone marker, so the scrolling note's erase never leaves a hole in it.
  - The marker is the SIZE×SIZE outline at (HIT_X, LANE_Y), colour 111.
  - MARK lasts SIZE² cycles; vga_plot=1 only on edge pixels (px or py equal to 0 or SIZE-1).
  - The sprite is drawn first; the marker overwrites it.
- HIT_ZONE_EN undefined: no MARK state and no marker logic.

Decomposition:
- Shared package taiko_pkg holds:
  - state enum for this block;
  - SCREEN_W=160 and SCREEN_H=120;
  - colour constants BLACK=000, RED=100, BLUE=001, WHITE=111.
- One sub-module: sprite_raster_counter (px/py counters, last-pixel flag, clear input), reused by ERASE, DRAW and MARK.

Test Plan:
- Reset, then frame_tick with note_x=100, note_color=100 → no erase; 64 plots covering x 100..107, y 56..63, colour 100; done at cycle 65; busy low after.
- Then frame_tick with note_x=99 → 64 plots with colour 000 at x 100..107, then 64 plots with colour 100 at x 99..106; done 129 cycles after the tick.
- Clipping: first frame_tick with note_x=159 → 64 DRAW cycles with only 8 plots (x=159, y 56..63); the other 56 cycles have vga_plot=0.
- Repeated tick with unchanged x=99 and colour → zero plots; done pulses the cycle after the tick.
- frame_tick asserted at cycle 10 of ERASE → ignored; exactly one done per accepted tick.
- resetn low at DRAW cycle 20 → next cycle all outputs 0 and busy=0. The next frame_tick with note_x=50 performs no erase (have_old cleared).
